br_pred_unit: RTL and testbench
===============================

Name: br_pred_unit

Overview:
Parametrised successor to the combinational branch/next-PC block. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, giving fetch-stage predictions. Includes an in-block comparator for all six RV32I conditional ops. Resolves the real next PC in execute and flags mispredictions so the pipeline can flush and redirect.

Parameters:
DATA_WIDTH, 32, PC/operand width
BR_OP_WIDTH, 3, branch op width (RV32I funct3 encoding)
BTB_IDX_WIDTH, 4, log2 of BTB entries (16 entries); tag = PC[DATA_WIDTH-1:BTB_IDX_WIDTH+2]
CTR_RESET, 2'b01, counter value at reset (weakly not-taken)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
fetch_pc_i  in  DATA_WIDTH  PC being fetched
pred_taken_o  out  1  prediction for fetch_pc_i
pred_pc_o  out  DATA_WIDTH  predicted next PC
ex_valid_i  in  1  execute-stage instruction valid
ex_pc_i  in  DATA_WIDTH  PC of execute-stage instruction
is_branch_i  in  1  instruction is branch or jump
is_conditional_i  in  1  1 = Bxx, 0 = JAL/JALR
BR_op_i  in  BR_OP_WIDTH  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
rs1_i  in  DATA_WIDTH  comparator operand A
rs2_i  in  DATA_WIDTH  comparator operand B
imm_i  in  DATA_WIDTH  sign-extended branch offset
jump_target_i  in  DATA_WIDTH  JAL/JALR target from ALU
ex_pred_pc_i  in  DATA_WIDTH  pred_pc_o that was issued with this instruction
pc_4_o  out  DATA_WIDTH  ex_pc_i + 4 (link value)
new_pc_o  out  DATA_WIDTH  resolved next PC
mispredict_o  out  1  redirect/flush request

Behaviour:
- BTB entry: valid, tag, target[DATA_WIDTH], uncond flag, ctr[1:0]. Index = PC[BTB_IDX_WIDTH+1:2].
- Reset (clk edge with rst_i=1): all valid=0; all ctr=CTR_RESET. While rst_i=1: pred_taken_o=0, pred_pc_o=fetch_pc_i+4, mispredict_o=0, no table write.
- Fetch lookup is combinational from registered table state. hit = valid & tag match. pred_taken_o = hit & (uncond | ctr[1]). pred_pc_o = pred_taken_o ? target : fetch_pc_i+4.
- Resolve (combinational, active when ex_valid_i=1):
  - Comparisons: EQ/NE use equality; LT/GE are signed; LTU/GEU are unsigned. Ops 010/011 are never taken.
  - taken = conditional ? compare result : 1.
  - actual target = conditional ? ex_pc_i+imm_i : {jump_target_i[DATA_WIDTH-1:1],1'b0}.
  - new_pc_o = taken ? actual target : ex_pc_i+4.
  - mispredict_o = ex_valid_i & (new_pc_o != ex_pred_pc_i).
  - When ex_valid_i=0: new_pc_o = ex_pc_i+4 and mispredict_o=0.
  - pc_4_o is always ex_pc_i+4. All adds wrap modulo 2^DATA_WIDTH.
- Update on clk edge (ex_valid_i=1, rst_i=0), entry at ex_pc_i index:
  - Branch, taken: write valid=1, tag, target, uncond=~is_conditional_i. On hit, ctr saturates up (max 11). On miss/replace, ctr=2'b10.
  - Branch, not taken, hit: ctr saturates down (min 00). Target unchanged.
  - Branch, not taken, miss: no write.
  - Non-branch with hit (alias): clear valid.
- Same-cycle fetch and update to one index: the lookup sees pre-update contents; the write is visible the next cycle.
- A reset asserted mid-sequence discards the pending update; the table is fully cleared after that edge.
- Latency: prediction 0 cycles; training visible 1 cycle after the resolve edge.

Optional Feature:
BR_PERF_CNT_EN
- Defined: adds outputs br_cnt_o[31:0] and mispred_cnt_o[31:0].
  - br_cnt_o increments on each clk edge with ex_valid_i & is_branch_i.
  - mispred_cnt_o increments on each edge with mispredict_o=1.
  - Both counters wrap at 2^32 and clear on rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then fetch_pc_i=0x100 -> pred_taken_o=0, pred_pc_o=0x104. Bench checks all 16 entries miss.
2. BEQ at 0x100, rs1=rs2=5, imm=0x20, ex_pred_pc_i=0x104 -> new_pc_o=0x120, mispredict_o=1. Next cycle fetch 0x100 -> pred_taken_o=1, pred_pc_o=0x120.
3. Same BEQ resolved with rs1=1, rs2=2 twice -> ctr goes 10->01->00. pred_taken_o=0 after the first update. A third not-taken keeps ctr=00.
4. BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with same operands -> not taken (new_pc_o=ex_pc+4). Op 010 -> not taken.
5. JALR at 0x200, jump_target_i=0x305 -> new_pc_o=0x304, pc_4_o=0x204. Then fetch 0x200 -> pred_pc_o=0x304, since the uncond entry predicts taken regardless of ctr.
6. Aliasing: 0x140 shares the index of 0x100 with a different tag -> miss. A non-branch at 0x100 with a valid entry clears it. rst_i asserted the same cycle as a taken resolve -> no entry written.

Source files
------------

// File: rtl/br_pred_unit.sv
// br_pred_unit: fetch-stage branch predictor backed by a direct-mapped BTB
// with 2-bit saturating counters, plus execute-stage branch resolution and
// mispredict detection for the RV32I conditional branches and JAL/JALR.
// Optional macro BR_PERF_CNT_EN adds branch and misprediction counters.
module br_pred_unit #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         BR_OP_WIDTH   = 3,
  parameter int         BTB_IDX_WIDTH = 4,
  parameter logic [1:0] CTR_RESET     = 2'b01
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  fetch_pc_i,
  output logic                   pred_taken_o,
  output logic [DATA_WIDTH-1:0]  pred_pc_o,
  input  logic                   ex_valid_i,
  input  logic [DATA_WIDTH-1:0]  ex_pc_i,
  input  logic                   is_branch_i,
  input  logic                   is_conditional_i,
  input  logic [BR_OP_WIDTH-1:0] BR_op_i,
  input  logic [DATA_WIDTH-1:0]  rs1_i,
  input  logic [DATA_WIDTH-1:0]  rs2_i,
  input  logic [DATA_WIDTH-1:0]  imm_i,
  input  logic [DATA_WIDTH-1:0]  jump_target_i,
  input  logic [DATA_WIDTH-1:0]  ex_pred_pc_i,
  output logic [DATA_WIDTH-1:0]  pc_4_o,
  output logic [DATA_WIDTH-1:0]  new_pc_o,
  output logic                   mispredict_o
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]            br_cnt_o,
  output logic [31:0]            mispred_cnt_o
`endif
);

  localparam int ENTRIES = 1 << BTB_IDX_WIDTH;
  localparam int TAG_LSB = BTB_IDX_WIDTH + 2;
  localparam int TAG_W   = DATA_WIDTH - TAG_LSB;

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic                  uncond_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [BTB_IDX_WIDTH-1:0] f_idx;
  logic                     f_hit;
  logic [BTB_IDX_WIDTH-1:0] e_idx;
  logic [TAG_W-1:0]         e_tag;
  logic                     e_hit;
  logic                     cmp_taken;
  logic                     br_taken;
  logic [DATA_WIDTH-1:0]    act_target;
  logic [1:0]               ctr_up;
  logic [1:0]               ctr_dn;

  // Fetch lookup reads the registered table, so a same-cycle update is not seen
  assign f_idx        = fetch_pc_i[TAG_LSB-1:2];
  assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == fetch_pc_i[DATA_WIDTH-1:TAG_LSB]);
  assign pred_taken_o = !rst_i && f_hit && (uncond_q[f_idx] || ctr_q[f_idx][1]);
  assign pred_pc_o    = pred_taken_o ? target_q[f_idx] : fetch_pc_i + DATA_WIDTH'(4);

  // Branch comparator; funct3 codes 010/011 are not branches and never take
  always_comb begin
    cmp_taken = 1'b0;
    case (BR_op_i)
      BR_OP_WIDTH'(3'b000): cmp_taken = (rs1_i == rs2_i);
      BR_OP_WIDTH'(3'b001): cmp_taken = (rs1_i != rs2_i);
      BR_OP_WIDTH'(3'b100): cmp_taken = ($signed(rs1_i) <  $signed(rs2_i));
      BR_OP_WIDTH'(3'b101): cmp_taken = ($signed(rs1_i) >= $signed(rs2_i));
      BR_OP_WIDTH'(3'b110): cmp_taken = (rs1_i <  rs2_i);
      BR_OP_WIDTH'(3'b111): cmp_taken = (rs1_i >= rs2_i);
      default:              cmp_taken = 1'b0;
    endcase
  end

  // Resolution: jumps always take and clear bit 0 of the ALU target
  assign br_taken     = is_branch_i && (is_conditional_i ? cmp_taken : 1'b1);
  assign act_target   = is_conditional_i ? (ex_pc_i + imm_i)
                                         : (jump_target_i & {{(DATA_WIDTH-1){1'b1}}, 1'b0});
  assign pc_4_o       = ex_pc_i + DATA_WIDTH'(4);
  assign new_pc_o     = (ex_valid_i && br_taken) ? act_target : pc_4_o;
  assign mispredict_o = ex_valid_i && !rst_i && (new_pc_o != ex_pred_pc_i);

  // Execute-side view of the entry being trained
  assign e_idx  = ex_pc_i[TAG_LSB-1:2];
  assign e_tag  = ex_pc_i[DATA_WIDTH-1:TAG_LSB];
  assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign ctr_up = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'b01;
  assign ctr_dn = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'b01;

  // Valid bits and counters: cleared on reset, trained by resolved instructions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (ex_valid_i) begin
      if (br_taken) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= e_hit ? ctr_up : 2'b10;
      end else if (is_branch_i && e_hit) begin
        ctr_q[e_idx]   <= ctr_dn;
      end else if (!is_branch_i && e_hit) begin
        valid_q[e_idx] <= 1'b0;
      end
    end
  end

  // Tag, target and jump flag are only meaningful while valid, so no reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && ex_valid_i && br_taken) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= act_target;
      uncond_q[e_idx] <= !is_conditional_i;
    end
  end

`ifdef BR_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_o      <= 32'd0;
      mispred_cnt_o <= 32'd0;
    end else begin
      if (ex_valid_i && is_branch_i) br_cnt_o <= br_cnt_o + 32'd1;
      if (mispredict_o)              mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_pred_unit.sv
// tb_br_pred_unit: directed self-checking bench for br_pred_unit covering
// reset, BTB training, counter saturation, the comparator, jumps, aliasing,
// back-to-back updates and reset colliding with an update.
module tb_br_pred_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        is_branch;
  logic        is_conditional;
  logic [2:0]  br_op;
  logic [31:0] rs1, rs2, imm, jump_target, ex_pred_pc;
  logic [31:0] pc_4, new_pc;
  logic        mispredict;
`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt, mispred_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  br_pred_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_pc_i       (fetch_pc),
    .pred_taken_o     (pred_taken),
    .pred_pc_o        (pred_pc),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .is_branch_i      (is_branch),
    .is_conditional_i (is_conditional),
    .BR_op_i          (br_op),
    .rs1_i            (rs1),
    .rs2_i            (rs2),
    .imm_i            (imm),
    .jump_target_i    (jump_target),
    .ex_pred_pc_i     (ex_pred_pc),
    .pc_4_o           (pc_4),
    .new_pc_o         (new_pc),
    .mispredict_o     (mispredict)
`ifdef BR_PERF_CNT_EN
    ,
    .br_cnt_o         (br_cnt),
    .mispred_cnt_o    (mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ex(input logic v, input logic br, input logic cond, input logic [2:0] op,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] jt, input logic [31:0] pp);
    ex_valid = v; is_branch = br; is_conditional = cond; br_op = op;
    ex_pc = pc; rs1 = a; rs2 = b; imm = im; jump_target = jt; ex_pred_pc = pp;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_pc = 32'h100;
    set_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); tick();
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h110, 32'h5, 32'h5, 32'h20, 32'h0, 32'h114);
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("[TB] FAIL rst_pred_taken: got %b want 0", pred_taken); end
    n_cmp++; if (pred_pc !== 32'h104) begin n_err++; $display("[TB] FAIL rst_pred_pc: got %h want 00000104", pred_pc); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("[TB] FAIL rst_mispredict: got %b want 0", mispredict); end
    tick();
    rst = 1'b0;
    idle_ex();
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 32'h100 + 32'(4 * i);
      #1;
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_pc !== fetch_pc + 32'd4) begin
        n_err++;
        $display("[TB] FAIL empty_entry_%0d: got taken=%b pc=%h want taken=0 pc=%h", i, pred_taken, pred_pc, fetch_pc + 32'd4);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_beq_train();
    fetch_pc = 32'h100;
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h100, 32'h5, 32'h5, 32'h20, 32'h0, 32'h104);
    #1;
    n_cmp++; if (new_pc !== 32'h120) begin n_err++; $display("[TB] FAIL beq_new_pc: got %h want 00000120", new_pc); end
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("[TB] FAIL beq_mispredict: got %b want 1", mispredict); end
    n_cmp++; if (pc_4 !== 32'h104) begin n_err++; $display("[TB] FAIL beq_pc_4: got %h want 00000104", pc_4); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("[TB] FAIL beq_same_cycle_lookup: got %b want 0", pred_taken); end
    tick();
    idle_ex();
    #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("[TB] FAIL beq_trained_taken: got %b want 1", pred_taken); end
    n_cmp++; if (pred_pc !== 32'h120) begin n_err++; $display("[TB] FAIL beq_trained_pc: got %h want 00000120", pred_pc); end
    n_cmp++; if (new_pc !== 32'h104) begin n_err++; $display("[TB] FAIL idle_new_pc: got %h want 00000104", new_pc); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("[TB] FAIL idle_mispredict: got %b want 0", mispredict); end
    @(negedge clk);
  endtask

  // Counter walk from 10: three not-taken (saturate at 00), three taken
  // (to 11), then one not-taken leaves it at 10 and still predicted taken.
  task automatic test_counter();
    logic [31:0] a_v  [7] = '{32'h1, 32'h1, 32'h1, 32'h5, 32'h5, 32'h5, 32'h1};
    logic [31:0] pp_v [7] = '{32'h120, 32'h104, 32'h104, 32'h104, 32'h104, 32'h120, 32'h120};
    logic [31:0] np_v [7] = '{32'h104, 32'h104, 32'h104, 32'h120, 32'h120, 32'h120, 32'h104};
    logic        mp_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        pt_v [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fetch_pc = 32'h100;
    for (int i = 0; i < 7; i++) begin
      set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h100, a_v[i], 32'h5, 32'h20, 32'h0, pp_v[i]);
      if (a_v[i] == 32'h1) rs2 = 32'h2;
      #1;
      n_cmp++; if (new_pc !== np_v[i]) begin n_err++; $display("[TB] FAIL ctr_step%0d_new_pc: got %h want %h", i, new_pc, np_v[i]); end
      n_cmp++; if (mispredict !== mp_v[i]) begin n_err++; $display("[TB] FAIL ctr_step%0d_mispredict: got %b want %b", i, mispredict, mp_v[i]); end
      tick();
      idle_ex();
      #1;
      n_cmp++;
      if (pred_taken !== pt_v[i] || pred_pc !== (pt_v[i] ? 32'h120 : 32'h104)) begin
        n_err++;
        $display("[TB] FAIL ctr_step%0d_pred: got taken=%b pc=%h want taken=%b pc=%h", i, pred_taken, pred_pc, pt_v[i], pt_v[i] ? 32'h120 : 32'h104);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_compare();
    logic [2:0]  op_v [11] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b001, 3'b101, 3'b111, 3'b101, 3'b000, 3'b000};
    logic [31:0] a_v  [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h3, 32'h4, 32'h1, 32'h1, 32'h5, 32'h7, 32'h9};
    logic [31:0] b_v  [11] = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h4, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h8, 32'h9};
    logic [31:0] im_v [11] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'hFFFFFFF0};
    logic [31:0] np_v [11] = '{32'h148, 32'h10C, 32'h10C, 32'h10C, 32'h148, 32'h10C, 32'h148, 32'h10C, 32'h148, 32'h10C, 32'hF8};
    for (int i = 0; i < 11; i++) begin
      set_ex(1'b1, 1'b1, 1'b1, op_v[i], 32'h108, a_v[i], b_v[i], im_v[i], 32'h0, 32'h10C);
      #1;
      n_cmp++; if (new_pc !== np_v[i]) begin n_err++; $display("[TB] FAIL cmp_vec%0d_new_pc: got %h want %h", i, new_pc, np_v[i]); end
      n_cmp++; if (mispredict !== (np_v[i] != 32'h10C)) begin n_err++; $display("[TB] FAIL cmp_vec%0d_mispredict: got %b want %b", i, mispredict, np_v[i] != 32'h10C); end
      idle_ex();
      @(negedge clk);
    end
    ex_pc = 32'hFFFFFFFC;
    #1;
    n_cmp++; if (pc_4 !== 32'h0) begin n_err++; $display("[TB] FAIL pc_4_wrap: got %h want 00000000", pc_4); end
    @(negedge clk);
  endtask

  task automatic test_jalr();
    set_ex(1'b1, 1'b1, 1'b0, 3'b000, 32'h200, 32'h1, 32'h2, 32'h0, 32'h305, 32'h204);
    #1;
    n_cmp++; if (new_pc !== 32'h304) begin n_err++; $display("[TB] FAIL jalr_new_pc: got %h want 00000304", new_pc); end
    n_cmp++; if (pc_4 !== 32'h204) begin n_err++; $display("[TB] FAIL jalr_pc_4: got %h want 00000204", pc_4); end
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("[TB] FAIL jalr_mispredict: got %b want 1", mispredict); end
    tick();
    idle_ex();
    fetch_pc = 32'h200;
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_pc !== 32'h304) begin n_err++; $display("[TB] FAIL jalr_pred: got taken=%b pc=%h want taken=1 pc=00000304", pred_taken, pred_pc); end
    fetch_pc = 32'h100;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h104) begin n_err++; $display("[TB] FAIL jalr_replaced: got taken=%b pc=%h want taken=0 pc=00000104", pred_taken, pred_pc); end
    @(negedge clk);
    // Drive the counter of the jump entry down to 00; the jump flag keeps it taken
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h200, 32'h1, 32'h2, 32'h40, 32'h0, 32'h304);
    #1;
    n_cmp++; if (new_pc !== 32'h204 || mispredict !== 1'b1) begin n_err++; $display("[TB] FAIL jalr_nt_resolve: got pc=%h mis=%b want pc=00000204 mis=1", new_pc, mispredict); end
    tick(); tick();
    idle_ex();
    fetch_pc = 32'h200;
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_pc !== 32'h304) begin n_err++; $display("[TB] FAIL uncond_ignores_ctr: got taken=%b pc=%h want taken=1 pc=00000304", pred_taken, pred_pc); end
    @(negedge clk);
  endtask

  task automatic test_alias();
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h100, 32'h5, 32'h5, 32'h20, 32'h0, 32'h104);
    tick();
    idle_ex();
    fetch_pc = 32'h140;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h144) begin n_err++; $display("[TB] FAIL alias_miss: got taken=%b pc=%h want taken=0 pc=00000144", pred_taken, pred_pc); end
    fetch_pc = 32'h100;
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_pc !== 32'h120) begin n_err++; $display("[TB] FAIL alias_owner_hit: got taken=%b pc=%h want taken=1 pc=00000120", pred_taken, pred_pc); end
    @(negedge clk);
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h140, 32'h0, 32'h0, 32'h0, 32'h0, 32'h144);
    tick();
    idle_ex();
    #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("[TB] FAIL nonbranch_tag_mismatch_keeps: got %b want 1", pred_taken); end
    @(negedge clk);
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h104);
    tick();
    idle_ex();
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h104) begin n_err++; $display("[TB] FAIL nonbranch_clears: got taken=%b pc=%h want taken=0 pc=00000104", pred_taken, pred_pc); end
    @(negedge clk);
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h104, 32'h1, 32'h2, 32'h20, 32'h0, 32'h108);
    tick();
    idle_ex();
    fetch_pc = 32'h104;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h108) begin n_err++; $display("[TB] FAIL nt_miss_no_write: got taken=%b pc=%h want taken=0 pc=00000108", pred_taken, pred_pc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h110, 32'h5, 32'h5, 32'h10, 32'h0, 32'h114);
    tick();
    set_ex(1'b1, 1'b1, 1'b1, 3'b001, 32'h114, 32'h1, 32'h2, 32'h8, 32'h0, 32'h118);
    fetch_pc = 32'h114;
    #1;
    n_cmp++; if (new_pc !== 32'h11C) begin n_err++; $display("[TB] FAIL b2b_bne_new_pc: got %h want 0000011c", new_pc); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_pre_update_lookup: got %b want 0", pred_taken); end
    fetch_pc = 32'h110;
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_pc !== 32'h120) begin n_err++; $display("[TB] FAIL b2b_first_visible: got taken=%b pc=%h want taken=1 pc=00000120", pred_taken, pred_pc); end
    tick();
    idle_ex();
    fetch_pc = 32'h114;
    #1;
    n_cmp++; if (pred_taken !== 1'b1 || pred_pc !== 32'h11C) begin n_err++; $display("[TB] FAIL b2b_second_visible: got taken=%b pc=%h want taken=1 pc=0000011c", pred_taken, pred_pc); end
    @(negedge clk);
  endtask

  task automatic test_reset_collision();
    set_ex(1'b1, 1'b1, 1'b1, 3'b000, 32'h118, 32'h5, 32'h5, 32'h10, 32'h0, 32'h11C);
    rst = 1'b1;
    fetch_pc = 32'h110;
    #1;
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("[TB] FAIL coll_mispredict: got %b want 0", mispredict); end
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h114) begin n_err++; $display("[TB] FAIL coll_pred_in_reset: got taken=%b pc=%h want taken=0 pc=00000114", pred_taken, pred_pc); end
    tick();
    rst = 1'b0;
    idle_ex();
    fetch_pc = 32'h118;
    #1;
    n_cmp++; if (pred_taken !== 1'b0 || pred_pc !== 32'h11C) begin n_err++; $display("[TB] FAIL coll_no_write: got taken=%b pc=%h want taken=0 pc=0000011c", pred_taken, pred_pc); end
    fetch_pc = 32'h110;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("[TB] FAIL coll_cleared_110: got %b want 0", pred_taken); end
    fetch_pc = 32'h114;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("[TB] FAIL coll_cleared_114: got %b want 0", pred_taken); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_beq_train();
    test_counter();
    test_compare();
    test_jalr();
    test_alias();
    test_back_to_back();
    test_reset_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
